c1_slave_port: RTL and testbench



---
 rtl/c1_slave_port_if.sv | 24 ++
 rtl/c1_slave_port.sv | 161 ++++++++++++++++
 tb/tb_c1_slave_port.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c1_slave_port_if.sv
// Core-side request/completion channel of the C1 slave port.
// The port drives the request (master modport); the cache core answers (slave modport).
interface c1_slave_port_if #(
    parameter int MEM_ADDR_SIZE = 19,
    parameter int BUS_SIZE      = 16
);
    logic                       req_valid;
    logic [2:0]                 req_op;
    logic [MEM_ADDR_SIZE-1:0]   req_addr;
    logic [2*BUS_SIZE-1:0]      req_wdata;
    logic                       core_done;
    logic [2*BUS_SIZE-1:0]      core_rdata;
    logic                       busy;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, busy,
        input  core_done, core_rdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, busy,
        output core_done, core_rdata
    );
endinterface

// File: rtl/c1_slave_port.sv
// C1 bus responder in front of the cache core.
// Decodes a two-cycle C1 request (tag+set, then offset), presents one parallel
// request to the core, waits for completion and returns the response on the
// shared bidirectional command/data buses. Both buses are released except in
// the response cycles. Command codes: 0 NOP, 1 READ8, 2 READ16, 3 READ32,
// 4 INV_LINE, 5 WRITE8, 6 WRITE16, 7 WRITE32 / RESP.
module c1_slave_port #(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                       data,
    inout  wire  [2:0]                                command,
    c1_slave_port_if.master                           core
);
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_READ8   = 3'd1;
    localparam logic [2:0] OP_READ16  = 3'd2;
    localparam logic [2:0] OP_READ32  = 3'd3;
    localparam logic [2:0] OP_WRITE8  = 3'd5;
    localparam logic [2:0] OP_WRITE16 = 3'd6;
    localparam logic [2:0] OP_WRITE32 = 3'd7;
    localparam logic [2:0] OP_RESP    = 3'd7;

    typedef enum logic [2:0] {IDLE, ADDR2, REQ, RESP1, RESP2} state_t;

    state_t                    state;
    state_t                    state_next;
    logic [2:0]                op;
    logic [MEM_ADDR_SIZE-1:0]  addr;
    logic [BUS_SIZE-1:0]       wlo;
    logic [BUS_SIZE-1:0]       whi;
    logic [2*BUS_SIZE-1:0]     rdata;
    logic [2*BUS_SIZE-1:0]     wdata;
    logic                      cmd_present;
    logic                      cmd_is_write;
    logic                      valid;
    logic                      drive_cmd;
    logic                      drive_data;
    logic [BUS_SIZE-1:0]       data_out;

    // A released (Z) or unknown command compares unknown, so the IDLE branch
    // is not taken and the port stays idle.
    assign cmd_present  = (command != OP_NOP);
    assign cmd_is_write = command[2] & (command[1:0] != 2'b00);

    // State register; asynchronous reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus core request and bus drive enables
    always_comb begin
        state_next = state;
        valid      = 1'b0;
        drive_cmd  = 1'b0;
        drive_data = 1'b0;
        data_out   = '0;
        case (state)
            IDLE: begin
                if (cmd_present) begin
                    state_next = ADDR2;
                end
            end
            ADDR2: begin
                state_next = REQ;
            end
            REQ: begin
                valid = 1'b1;
                if (core.core_done) begin
                    state_next = RESP1;
                end
            end
            RESP1: begin
                drive_cmd  = 1'b1;
                drive_data = (op == OP_READ8) || (op == OP_READ16) || (op == OP_READ32);
                if (op == OP_READ8) begin
                    data_out = {{(BUS_SIZE-8){1'b0}}, rdata[7:0]};
                end else begin
                    data_out = rdata[BUS_SIZE-1:0];
                end
                state_next = (op == OP_READ32) ? RESP2 : IDLE;
            end
            RESP2: begin
                drive_cmd  = 1'b1;
                drive_data = 1'b1;
                data_out   = rdata[2*BUS_SIZE-1:BUS_SIZE];
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture: op/tag+set/low write word on the first cycle, offset and
    // high (or repeated low) write word on the second, read data on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op    <= OP_NOP;
            addr  <= '0;
            wlo   <= '0;
            whi   <= '0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_present) begin
                        op <= command;
                        addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE] <= address;
                        if (cmd_is_write) begin
                            wlo <= data;
                        end
                    end
                end
                ADDR2: begin
                    addr[CACHE_OFFSET_SIZE-1:0] <= address[CACHE_OFFSET_SIZE-1:0];
                    if (op == OP_WRITE32) begin
                        whi <= data;
                    end else if ((op == OP_WRITE8) || (op == OP_WRITE16)) begin
                        wlo <= data;
                    end
                end
                REQ: begin
                    if (core.core_done) begin
                        rdata <= core.core_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Write data presented to the core, zero-extended to the core width
    always_comb begin
        wdata = '0;
        case (op)
            OP_WRITE8:  wdata = {{(2*BUS_SIZE-8){1'b0}}, wlo[7:0]};
            OP_WRITE16: wdata = {{BUS_SIZE{1'b0}}, wlo};
            OP_WRITE32: wdata = {whi, wlo};
            default:    wdata = '0;
        endcase
    end

    assign core.req_valid = valid;
    assign core.req_op    = op;
    assign core.req_addr  = addr;
    assign core.req_wdata = wdata;
    assign core.busy      = (state != IDLE);

    assign command = drive_cmd  ? OP_RESP  : 3'bzzz;
    assign data    = drive_data ? data_out : {BUS_SIZE{1'bz}};
endmodule

// File: tb/tb_c1_slave_port.sv
// Testbench for c1_slave_port: acts as the C1 bus master and the cache core,
// predicts outputs from a transaction-level model and compares every cycle.
module tb_c1_slave_port;
    localparam int MEM_ADDR_SIZE     = 19;
    localparam int BUS_SIZE          = 16;
    localparam int CACHE_OFFSET_SIZE = 4;

    logic        clk;
    logic        rst_n;
    logic [14:0] m_addr;
    logic [2:0]  m_cmd;
    logic        m_cmd_en;
    logic [15:0] m_data;
    logic        m_data_en;

    // Released command reads as NOP, released data reads as all ones.
    tri0 [2:0]  command;
    tri1 [15:0] data;

    assign command = m_cmd_en  ? m_cmd  : 3'bzzz;
    assign data    = m_data_en ? m_data : 16'hzzzz;

    c1_slave_port_if #(.MEM_ADDR_SIZE(MEM_ADDR_SIZE), .BUS_SIZE(BUS_SIZE)) core_bus ();

    c1_slave_port #(
        .MEM_ADDR_SIZE(MEM_ADDR_SIZE),
        .BUS_SIZE(BUS_SIZE),
        .CACHE_OFFSET_SIZE(CACHE_OFFSET_SIZE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .address(m_addr),
        .data(data),
        .command(command),
        .core(core_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    bit chk_en;

    // expected DUT outputs after the next rising edge
    bit          exp_busy;
    bit          exp_valid;
    logic [2:0]  exp_op;
    logic [18:0] exp_addr;
    logic [31:0] exp_wdata;
    bit          exp_cmd_drv;
    bit          exp_data_drv;
    logic [15:0] exp_data;

    // values sampled during the last transaction for literal pinning
    logic [2:0]  got_op;
    logic [18:0] got_addr;
    logic [31:0] got_wdata;
    logic [15:0] got_resp0;
    logic [15:0] got_resp1;
    logic [2:0]  got_cmd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---- transaction-level model ----
    function automatic logic [31:0] wdata_of(input logic [2:0] op, input logic [15:0] lo, input logic [15:0] hi);
        case (op)
            3'd5:    return {24'h0, lo[7:0]};
            3'd6:    return {16'h0, lo};
            3'd7:    return {hi, lo};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int data_words(input logic [2:0] op);
        if (op == 3'd3) return 2;
        if (op == 3'd1 || op == 3'd2) return 1;
        return 0;
    endfunction

    function automatic logic [15:0] resp_word(input logic [2:0] op, input logic [31:0] rd, input int idx);
        if (idx == 1) return rd[31:16];
        if (op == 3'd1) return {8'h00, rd[7:0]};
        return rd[15:0];
    endfunction

    task automatic set_exp_idle();
        exp_busy = 0; exp_valid = 0; exp_cmd_drv = 0; exp_data_drv = 0; exp_data = 16'h0;
    endtask

    task automatic set_exp_wait();
        exp_busy = 1; exp_valid = 0; exp_cmd_drv = 0; exp_data_drv = 0; exp_data = 16'h0;
    endtask

    task automatic set_exp_req(input logic [2:0] op, input logic [18:0] a, input logic [31:0] wd);
        exp_busy = 1; exp_valid = 1; exp_op = op; exp_addr = a; exp_wdata = wd;
        exp_cmd_drv = 0; exp_data_drv = 0;
    endtask

    task automatic set_exp_resp(input bit drv, input logic [15:0] w);
        exp_busy = 1; exp_valid = 0; exp_cmd_drv = 1; exp_data_drv = drv; exp_data = w;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic release_master();
        m_cmd_en = 0;
        m_data_en = 0;
    endtask

    // Compare process: every cycle, shortly after the rising edge
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("busy", 32'(core_bus.busy), 32'(exp_busy));
            chk("req_valid", 32'(core_bus.req_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("req_op", 32'(core_bus.req_op), 32'(exp_op));
                chk("req_addr", 32'(core_bus.req_addr), 32'(exp_addr));
                chk("req_wdata", core_bus.req_wdata, exp_wdata);
            end
            if (!m_cmd_en)
                chk("command", 32'(command), exp_cmd_drv ? 32'd7 : 32'd0);
            if (!m_data_en)
                chk("data", 32'(data), exp_data_drv ? 32'(exp_data) : 32'h0000FFFF);
        end
    end

    // Master: two request cycles, then release; ends at the first REQ negedge
    task automatic issue(input logic [2:0] op, input logic [18:0] a,
                         input logic [15:0] lo, input logic [15:0] hi, input bit early);
        logic [31:0] r;
        m_cmd = op; m_cmd_en = 1; m_addr = a[18:4];
        if (op >= 3'd5) begin m_data = lo; m_data_en = 1; end
        else m_data_en = 0;
        core_bus.core_done = early;
        set_exp_wait();
        tick();
        r = $urandom;
        m_addr = {r[10:0], a[3:0]};
        if (op == 3'd7) m_data = hi;
        else if (op >= 3'd5) m_data = lo;
        set_exp_req(op, a, wdata_of(op, lo, hi));
        tick();
        release_master();
    endtask

    // Core: hold off d cycles (optionally with bus noise), complete, take response
    task automatic complete(input logic [2:0] op, input logic [31:0] rd, input int d, input bit junk);
        logic [31:0] r;
        int ncyc;
        got_op = core_bus.req_op;
        got_addr = core_bus.req_addr;
        got_wdata = core_bus.req_wdata;
        for (int i = 0; i < d; i++) begin
            core_bus.core_done = 0;
            core_bus.core_rdata = $urandom;
            if (junk) begin
                r = $urandom;
                m_cmd = 3'(r % 7 + 1); m_cmd_en = 1;
                m_addr = r[14:0];
                m_data = r[31:16]; m_data_en = 1;
            end
            tick();
        end
        release_master();
        core_bus.core_done = 1;
        core_bus.core_rdata = rd;
        ncyc = (op == 3'd3) ? 2 : 1;
        for (int w = 0; w < ncyc; w++) begin
            set_exp_resp(w < data_words(op), resp_word(op, rd, w));
            tick();
            if (w == 0) begin got_resp0 = data; got_cmd0 = command; end
            else got_resp1 = data;
            core_bus.core_done = 0;
            core_bus.core_rdata = $urandom;
        end
        set_exp_idle();
        tick();
    endtask

    task automatic idle_gap(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            core_bus.core_done = noise;
            core_bus.core_rdata = $urandom;
            set_exp_idle();
            tick();
        end
        core_bus.core_done = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [18:0] a;
        logic [2:0]  op;
        n_vec = 0; n_err = 0; chk_en = 0;
        rst_n = 0;
        m_addr = '0; m_cmd = '0; m_data = '0; m_cmd_en = 0; m_data_en = 0;
        core_bus.core_done = 0; core_bus.core_rdata = '0;
        set_exp_idle();
        exp_op = '0; exp_addr = '0; exp_wdata = '0;
        #3;
        chk("reset_valid", 32'(core_bus.req_valid), 32'd0);
        chk("reset_busy", 32'(core_bus.busy), 32'd0);
        chk("reset_op", 32'(core_bus.req_op), 32'd0);
        chk("reset_addr", 32'(core_bus.req_addr), 32'd0);
        chk("reset_wdata", core_bus.req_wdata, 32'd0);
        chk("reset_command", 32'(command), 32'd0);
        chk("reset_data", 32'(data), 32'h0000FFFF);
        tick();
        rst_n = 1;
        chk_en = 1;
        idle_gap(2, 0);

        // READ8, core answers after 2 wait cycles
        issue(3'd1, 19'b0000000000_01110_0000, 16'h0, 16'h0, 0);
        complete(3'd1, 32'h000000A5, 2, 0);
        chk("read8_addr", 32'(got_addr), 32'(19'b0000000000_01110_0000));
        chk("read8_data", 32'(got_resp0), 32'h000000A5);
        chk("read8_cmd", 32'(got_cmd0), 32'd7);

        // WRITE16
        issue(3'd6, 19'h2A5C3, 16'hFF00, 16'h1234, 0);
        complete(3'd6, 32'h11223344, 1, 0);
        chk("write16_op", 32'(got_op), 32'd6);
        chk("write16_wdata", got_wdata, 32'h0000FF00);
        chk("write16_data_released", 32'(got_resp0), 32'h0000FFFF);
        chk("write16_cmd", 32'(got_cmd0), 32'd7);

        // WRITE32 then READ32 with core_done already high
        issue(3'd7, 19'h12345, 16'h5555, 16'hAAAA, 0);
        complete(3'd7, 32'h0, 0, 0);
        chk("write32_wdata", got_wdata, 32'hAAAA5555);
        issue(3'd3, 19'h12345, 16'h0, 16'h0, 1);
        complete(3'd3, 32'hF0F00F0F, 0, 0);
        chk("read32_lo", 32'(got_resp0), 32'h00000F0F);
        chk("read32_hi", 32'(got_resp1), 32'h0000F0F0);

        // INV_LINE with a long core stall
        issue(3'd4, 19'b0000000000_10001_0000, 16'h0, 16'h0, 0);
        complete(3'd4, 32'hDEADBEEF, 10, 0);
        chk("inv_op", 32'(got_op), 32'd4);
        chk("inv_addr", 32'(got_addr), 32'(19'b0000000000_10001_0000));

        // reset asserted while the request is outstanding
        issue(3'd2, 19'h7F0F3, 16'h0, 16'h0, 0);
        tick();
        chk_en = 0;
        #1 rst_n = 0;
        #1;
        chk("midrst_valid", 32'(core_bus.req_valid), 32'd0);
        chk("midrst_busy", 32'(core_bus.busy), 32'd0);
        chk("midrst_command", 32'(command), 32'd0);
        chk("midrst_data", 32'(data), 32'h0000FFFF);
        chk("midrst_op", 32'(core_bus.req_op), 32'd0);
        chk("midrst_addr", 32'(core_bus.req_addr), 32'd0);
        tick();
        rst_n = 1;
        core_bus.core_done = 1;
        core_bus.core_rdata = 32'hCAFEF00D;
        set_exp_idle();
        chk_en = 1;
        tick();
        tick();
        core_bus.core_done = 0;
        issue(3'd2, 19'h0ABC7, 16'h0, 16'h0, 0);
        complete(3'd2, 32'h1234BEEF, 1, 0);
        chk("post_rst_read16", 32'(got_resp0), 32'h0000BEEF);

        // core_done noise in IDLE, bus commands during REQ
        idle_gap(3, 1);
        issue(3'd1, 19'h3C3C9, 16'h0, 16'h0, 0);
        complete(3'd1, 32'h7777775A, 3, 1);
        chk("noise_addr", 32'(got_addr), 32'h0003C3C9);
        chk("noise_read8", 32'(got_resp0), 32'h0000005A);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            r = $urandom;
            op = 3'($urandom_range(1, 7));
            a = r[18:0];
            idle_gap($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            issue(op, a, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            complete(op, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        idle_gap(2, 0);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
